// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: sweeps one shared neuron-update datapath over all virtual neurons per TICK
module neuron_update_scheduler #(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 4,
  parameter int DP_LATENCY  = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             TICK,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVERRUN,
  output logic [IDX_W-1:0] MEM_ADDR,
  output logic             MEM_RD,
  input  logic [63:0]      MEM_RDATA,
  output logic             MEM_WR,
  output logic [63:0]      MEM_WDATA,
  output logic             DP_VALID_IN,
  output logic [31:0]      DP_V_IN,
  output logic [31:0]      DP_U_IN,
  input  logic [31:0]      DP_V_OUT,
  input  logic [31:0]      DP_U_OUT,
  input  logic             DP_SPIKED,
  output logic             SPIKE_VALID,
  output logic [IDX_W-1:0] SPIKE_IDX,
  input  logic             SPIKE_READY
);
  localparam int CW = $clog2(DP_LATENCY + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, READ, ISSUE, WAIT, WRITE, FIN} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      v_res_q, v_res_d, u_res_q, u_res_d;
  logic             spk_q, spk_d, ovr_q, ovr_d;
  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [IDX_W-1:0] fifo_d [FIFO_DEPTH];
  logic [PW:0]      wp_q, wp_d, rp_q, rp_d;
  logic             empty, full, pop, push, stall, last_wait, last_idx;
  assign empty     = wp_q == rp_q;
  assign full      = (wp_q[PW-1:0] == rp_q[PW-1:0]) && (wp_q[PW] != rp_q[PW]);
  assign pop       = !empty && SPIKE_READY;
  // a spiking write may only commit when its index can enter the FIFO on the same edge
  assign stall     = state_q == WRITE && spk_q && full && !pop;
  assign push      = state_q == WRITE && spk_q && !stall;
  assign last_wait = cnt_q == CW'(DP_LATENCY - 1);
  assign last_idx  = idx_q == IDX_W'(NUM_NEURONS - 1);
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      v_res_q <= '0;
      u_res_q <= '0;
      spk_q   <= 1'b0;
      ovr_q   <= 1'b0;
      fifo_q  <= '{default: '0};
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      v_res_q <= v_res_d;
      u_res_q <= u_res_d;
      spk_q   <= spk_d;
      ovr_q   <= ovr_d;
      fifo_q  <= fifo_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    v_res_d = v_res_q;
    u_res_d = u_res_q;
    spk_d   = spk_q;
    ovr_d   = TICK && state_q != IDLE;
    fifo_d  = fifo_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    case (state_q)
      IDLE:  state_d = TICK ? READ : IDLE;
      READ:  state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (last_wait) begin
          state_d = WRITE;
          v_res_d = DP_V_OUT;
          u_res_d = DP_U_OUT;
          spk_d   = DP_SPIKED;
        end
      end
      WRITE: if (!stall) begin
        state_d = last_idx ? FIN : READ;
        idx_d   = last_idx ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (push) begin
      fifo_d[wp_q[PW-1:0]] = idx_q;
      wp_d = wp_q + 1'b1;
    end
    if (pop) rp_d = rp_q + 1'b1;
  end
  always_comb begin
    BUSY        = state_q != IDLE;
    DONE        = state_q == FIN;
    OVERRUN     = ovr_q;
    MEM_ADDR    = idx_q;
    MEM_RD      = state_q == READ;
    MEM_WR      = state_q == WRITE && !stall;
    MEM_WDATA   = {v_res_q, u_res_q};
    DP_VALID_IN = state_q == ISSUE;
    DP_V_IN     = state_q == ISSUE ? MEM_RDATA[63:32] : '0;
    DP_U_IN     = state_q == ISSUE ? MEM_RDATA[31:0] : '0;
    SPIKE_VALID = !empty;
    SPIKE_IDX   = fifo_q[rp_q[PW-1:0]];
  end
endmodule
